// File: rtl/data_memory_if.sv
// Bus bundle for data_memory: request/response handshake, clear control and the
// flat debug view of the array.
interface data_memory_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int DEPTH = 1 << ADDR_W;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_rw;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic [DATA_W/8-1:0]       req_be;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      clr_req;
  logic                      busy;
  logic                      clr_done;
  logic [DATA_W*DEPTH-1:0]   mem_dump;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, req_be, rsp_ready, clr_req,
    input  req_ready, rsp_valid, rsp_data, busy, clr_done, mem_dump
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, req_be, rsp_ready, clr_req,
    output req_ready, rsp_valid, rsp_data, busy, clr_done, mem_dump
  );
endinterface

// File: rtl/data_memory.sv
// Single-port data memory for the CPU memory stage: byte-enabled writes, registered
// read response with backpressure, and a one-word-per-cycle clear sweep.
module data_memory #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic          clk,
  input  logic          clr_n,
  data_memory_if.slave  bus
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                busy_q;
  logic                clr_done_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;

  logic [DATA_W-1:0]       mem_w [DEPTH];
  logic [DATA_W*DEPTH-1:0] dump_w;

  logic req_ready;
  logic accept;
  logic wr_en;
  logic rd_en;
  logic sweep_en;

  // clr_req blocks acceptance in the same cycle so the sweep wins any collision.
  assign req_ready = (state_q == IDLE) && !bus.clr_req && (!rsp_valid_q || bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;
  assign wr_en     = accept && bus.req_rw;
  assign rd_en     = accept && !bus.req_rw;
  assign sweep_en  = (state_q == CLEAR);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A read accepted on the consuming edge keeps rsp_valid high with fresh data.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_en) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= mem_w[bus.req_addr];
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;

    always_comb begin
      word_d = word_q;
      if (sweep_en && (cnt_q == ADDR_W'(gi))) begin
        word_d = '0;
      end else if (wr_en && (bus.req_addr == ADDR_W'(gi))) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (bus.req_be[b]) begin
            word_d[8*b +: 8] = bus.req_wdata[8*b +: 8];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign mem_w[gi] = word_q;
  end

  always_comb begin
    dump_w = '0;
    for (int k = 0; k < DEPTH; k++) begin
      dump_w[k*DATA_W +: DATA_W] = mem_w[k];
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.clr_done  = clr_done_q;
  assign bus.mem_dump  = dump_w;
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a 16x8 instance and a 32x16 instance.
module tb_data_memory;
  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  data_memory_if #(.DATA_W(16), .ADDR_W(3)) bus_a ();
  data_memory_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();

  data_memory #(.DATA_W(16), .ADDR_W(3)) dut_a (.clk(clk), .clr_n(rst_a_n), .bus(bus_a));
  data_memory #(.DATA_W(32), .ADDR_W(4)) dut_b (.clk(clk), .clr_n(rst_b_n), .bus(bus_b));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [2:0] addr, input logic [15:0] data, input logic [1:0] be);
    bus_a.req_valid = 1'b1; bus_a.req_rw = 1'b1; bus_a.req_addr = addr;
    bus_a.req_wdata = data; bus_a.req_be = be;
    cyc();
    bus_a.req_valid = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    bus_a.req_valid = 1'b1; bus_a.req_rw = 1'b0; bus_a.req_addr = addr; bus_a.rsp_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, 512'(bus_a.req_ready), 512'(1'b1));
    cyc();
    bus_a.req_valid = 1'b0;
    chk({tag, "_valid"}, 512'(bus_a.rsp_valid), 512'(1'b1));
    chk({tag, "_data"}, 512'(bus_a.rsp_data), 512'(exp));
  endtask

  task automatic wr_b(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus_b.req_valid = 1'b1; bus_b.req_rw = 1'b1; bus_b.req_addr = addr;
    bus_b.req_wdata = data; bus_b.req_be = be;
    cyc();
    bus_b.req_valid = 1'b0;
  endtask

  task automatic rd_b(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    bus_b.req_valid = 1'b1; bus_b.req_rw = 1'b0; bus_b.req_addr = addr; bus_b.rsp_ready = 1'b1;
    cyc();
    bus_b.req_valid = 1'b0;
    chk({tag, "_valid"}, 512'(bus_b.rsp_valid), 512'(1'b1));
    chk({tag, "_data"}, 512'(bus_b.rsp_data), 512'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] exp_a;
    logic [127:0] exp_cur;
    logic [511:0] exp_b;
    int busy_cycles;

    bus_a.req_valid = 0; bus_a.req_rw = 0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_a.req_be = '0; bus_a.rsp_ready = 1; bus_a.clr_req = 0;
    bus_b.req_valid = 0; bus_b.req_rw = 0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    bus_b.req_be = '0; bus_b.rsp_ready = 1; bus_b.clr_req = 0;

    // Reset state
    #2;
    chk("rst_rsp_valid", 512'(bus_a.rsp_valid), 512'(1'b0));
    chk("rst_rsp_data", 512'(bus_a.rsp_data), 512'(16'h0));
    chk("rst_busy", 512'(bus_a.busy), 512'(1'b0));
    chk("rst_clr_done", 512'(bus_a.clr_done), 512'(1'b0));
    chk("rst_dump", 512'(bus_a.mem_dump), 512'(128'h0));
    chk("rst_b_dump", bus_b.mem_dump, 512'h0);
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    cyc();

    // 1: write then read
    wr_a(3'd5, 16'hBEEF, 2'b11);
    chk("t1_dump5", 512'(bus_a.mem_dump[95:80]), 512'(16'hBEEF));
    rd_a("t1_rd5", 3'd5, 16'hBEEF);
    cyc();
    chk("t1_rsp_drop", 512'(bus_a.rsp_valid), 512'(1'b0));

    // 2: byte enables
    wr_a(3'd2, 16'h1234, 2'b11);
    wr_a(3'd2, 16'hABCD, 2'b10);
    rd_a("t2_rd2", 3'd2, 16'hAB34);
    wr_a(3'd2, 16'hFFFF, 2'b00);
    chk("t2_be0", 512'(bus_a.mem_dump[47:32]), 512'(16'hAB34));
    chk("t2_rsp_taken", 512'(bus_a.rsp_valid), 512'(1'b0));

    // 3: backpressure
    bus_a.rsp_ready = 1'b0;
    bus_a.req_valid = 1'b1; bus_a.req_rw = 1'b0; bus_a.req_addr = 3'd5;
    cyc();
    bus_a.req_addr = 3'd2;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", 512'(bus_a.rsp_valid), 512'(1'b1));
      chk("t3_hold_data", 512'(bus_a.rsp_data), 512'(16'hBEEF));
      #1;
      chk("t3_stall_ready", 512'(bus_a.req_ready), 512'(1'b0));
      cyc();
    end
    bus_a.rsp_ready = 1'b1;
    #1;
    chk("t3_release_ready", 512'(bus_a.req_ready), 512'(1'b1));
    cyc();
    bus_a.req_valid = 1'b0;
    chk("t3_b2b_valid", 512'(bus_a.rsp_valid), 512'(1'b1));
    chk("t3_b2b_data", 512'(bus_a.rsp_data), 512'(16'hAB34));
    cyc();
    chk("t3_drain", 512'(bus_a.rsp_valid), 512'(1'b0));

    // 4: clear sweep
    exp_a = '0;
    for (int k = 0; k < 8; k++) begin
      wr_a(3'(k), 16'(16'h1111 * (k + 1)), 2'b11);
      exp_a[k*16 +: 16] = 16'(16'h1111 * (k + 1));
    end
    chk("t4_filled", 512'(bus_a.mem_dump), 512'(exp_a));
    bus_a.clr_req = 1'b1;
    #1;
    chk("t4_clr_ready", 512'(bus_a.req_ready), 512'(1'b0));
    cyc();
    bus_a.clr_req = 1'b0;
    bus_a.req_valid = 1'b1; bus_a.req_rw = 1'b1; bus_a.req_addr = 3'd0;
    bus_a.req_wdata = 16'h5555; bus_a.req_be = 2'b11;
    for (int i = 0; i < 8; i++) begin
      exp_cur = exp_a;
      for (int j = 0; j < i; j++) exp_cur[j*16 +: 16] = 16'h0;
      chk("t4_busy", 512'(bus_a.busy), 512'(1'b1));
      chk("t4_order", 512'(bus_a.mem_dump), 512'(exp_cur));
      chk("t4_ready_low", 512'(bus_a.req_ready), 512'(1'b0));
      cyc();
    end
    bus_a.req_rw = 1'b0; bus_a.req_addr = 3'd3;
    #1;
    chk("t4_busy_end", 512'(bus_a.busy), 512'(1'b0));
    chk("t4_done", 512'(bus_a.clr_done), 512'(1'b1));
    chk("t4_zeroed", 512'(bus_a.mem_dump), 512'(128'h0));
    chk("t4_ready_on_done", 512'(bus_a.req_ready), 512'(1'b1));
    cyc();
    chk("t4_done_pulse", 512'(bus_a.clr_done), 512'(1'b0));
    chk("t4_rd_valid", 512'(bus_a.rsp_valid), 512'(1'b1));
    chk("t4_rd_zero", 512'(bus_a.rsp_data), 512'(16'h0));

    // 5: clr_req beats a write; re-request mid-sweep is ignored
    bus_a.req_valid = 1'b1; bus_a.req_rw = 1'b1; bus_a.req_addr = 3'd1;
    bus_a.req_wdata = 16'h7777; bus_a.req_be = 2'b11; bus_a.clr_req = 1'b1;
    #1;
    chk("t5_collide_ready", 512'(bus_a.req_ready), 512'(1'b0));
    cyc();
    bus_a.req_valid = 1'b0; bus_a.clr_req = 1'b0;
    chk("t5_no_write", 512'(bus_a.mem_dump), 512'(128'h0));
    chk("t5_rsp_consumed", 512'(bus_a.rsp_valid), 512'(1'b0));
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_a.busy) break;
      busy_cycles++;
      bus_a.clr_req = (i >= 2 && i <= 4);
      cyc();
    end
    bus_a.clr_req = 1'b0;
    chk("t5_busy_len", 512'(busy_cycles), 512'(8));
    chk("t5_done", 512'(bus_a.clr_done), 512'(1'b1));
    cyc();
    chk("t5_no_restart", 512'(bus_a.busy), 512'(1'b0));

    // 6: async reset mid-sweep with a pending response
    wr_a(3'd6, 16'h6666, 2'b11);
    bus_a.rsp_ready = 1'b0;
    bus_a.req_valid = 1'b1; bus_a.req_rw = 1'b0; bus_a.req_addr = 3'd6;
    cyc();
    bus_a.req_valid = 1'b0; bus_a.clr_req = 1'b1;
    cyc();
    bus_a.clr_req = 1'b0;
    cyc(); cyc(); cyc();
    chk("t6_pending_kept", 512'(bus_a.rsp_data), 512'(16'h6666));
    chk("t6_pending_valid", 512'(bus_a.rsp_valid), 512'(1'b1));
    chk("t6_word6_live", 512'(bus_a.mem_dump[111:96]), 512'(16'h6666));
    rst_a_n = 1'b0;
    #1;
    chk("t6_rst_valid", 512'(bus_a.rsp_valid), 512'(1'b0));
    chk("t6_rst_data", 512'(bus_a.rsp_data), 512'(16'h0));
    chk("t6_rst_busy", 512'(bus_a.busy), 512'(1'b0));
    chk("t6_rst_dump", 512'(bus_a.mem_dump), 512'(128'h0));
    #1;
    rst_a_n = 1'b1;
    bus_a.rsp_ready = 1'b1;
    cyc();
    chk("t6_idle_after", 512'(bus_a.busy), 512'(1'b0));

    // 7: 32-bit x 16-word variant
    wr_b(4'd15, 32'hDEADBEEF, 4'b0101);
    chk("t7_dump15", 512'(bus_b.mem_dump[511:480]), 512'(32'h00AD00EF));
    rd_b("t7_rd15", 4'd15, 32'h00AD00EF);
    exp_b = '0;
    for (int k = 0; k < 16; k++) begin
      wr_b(4'(k), 32'(32'h01010101 * (k + 1)), 4'b1111);
      exp_b[k*32 +: 32] = 32'(32'h01010101 * (k + 1));
    end
    chk("t7_filled", bus_b.mem_dump, exp_b);
    bus_b.clr_req = 1'b1;
    cyc();
    bus_b.clr_req = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_b.busy) break;
      busy_cycles++;
      cyc();
    end
    chk("t7_busy_len", 512'(busy_cycles), 512'(16));
    chk("t7_done", 512'(bus_b.clr_done), 512'(1'b1));
    chk("t7_zeroed", bus_b.mem_dump, 512'h0);
    rd_b("t7_rd_zero", 4'd15, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
